// File: rtl/game_status_keeper_if.sv
// Bus between the asteroid objects / overlay renderer and game_status_keeper.
// hi_score_bcd exists only when HIGH_SCORE_EN is defined.
interface game_status_keeper_if #(
  parameter int NUM_AST = 4
);
  logic               pixpulse;
  logic               move;
  logic               start_btn;
  logic [NUM_AST-1:0] ast_dodged;
  logic               ship_hit;
  logic [15:0]        score_bcd;
  logic [2:0]         lives;
  logic               game_active;
  logic               freeze;
  logic               ast_respawn;
  logic               invuln;
  logic               game_over;
`ifdef HIGH_SCORE_EN
  logic [15:0]        hi_score_bcd;

  modport master (
    output pixpulse, move, start_btn, ast_dodged, ship_hit,
    input  score_bcd, lives, game_active, freeze, ast_respawn, invuln, game_over, hi_score_bcd
  );

  modport slave (
    input  pixpulse, move, start_btn, ast_dodged, ship_hit,
    output score_bcd, lives, game_active, freeze, ast_respawn, invuln, game_over, hi_score_bcd
  );
`else
  modport master (
    output pixpulse, move, start_btn, ast_dodged, ship_hit,
    input  score_bcd, lives, game_active, freeze, ast_respawn, invuln, game_over
  );

  modport slave (
    input  pixpulse, move, start_btn, ast_dodged, ship_hit,
    output score_bcd, lives, game_active, freeze, ast_respawn, invuln, game_over
  );
`endif
endinterface

// File: rtl/game_status_keeper.sv
// Score, lives and game-phase controller for the asteroid game, all updates on pixpulse.
// Defining HIGH_SCORE_EN adds a hi_score_bcd register captured on entry to GAME_OVER.
module game_status_keeper #(
  parameter int NUM_AST      = 4,
  parameter int START_LIVES  = 3,
  parameter int GRACE_FRAMES = 120,
  parameter int OVER_FRAMES  = 180
) (
  input logic                 clk,
  input logic                 rst,
  game_status_keeper_if.slave bus_io
);

  typedef enum logic [1:0] {ATTRACT, PLAY, GRACE, GAME_OVER} state_t;

  state_t      state_q;
  logic [15:0] scoreBcd_q;
  logic [2:0]  lives_q;
  logic [7:0]  frameCnt_q;
  logic        gameActive_q;
  logic        freeze_q;
  logic        astRespawn_q;
  logic        invuln_q;
  logic        gameOver_q;
  logic [15:0] scoreAdd_d;
  logic [4:0]  dodgeCount_d;
  logic [4:0]  carry_d;
  logic [4:0]  digitSum_d;
  logic        scoring;
`ifdef HIGH_SCORE_EN
  logic [15:0] hiScore_q;
  assign bus_io.hi_score_bcd = hiScore_q;
`endif

  assign scoring = (state_q == PLAY) || (state_q == GRACE);

  always_comb begin
    dodgeCount_d = '0;
    for (int i = 0; i < NUM_AST; i++) begin
      dodgeCount_d = dodgeCount_d + 5'(bus_io.ast_dodged[i]);
    end
  end

  // Ripple the dodge count through the digits; a carry out of the thousands digit saturates.
  always_comb begin
    scoreAdd_d = '0;
    carry_d    = dodgeCount_d;
    digitSum_d = '0;
    for (int d = 0; d < 4; d++) begin
      digitSum_d = {1'b0, scoreBcd_q[4*d +: 4]} + carry_d;
      if (digitSum_d > 5'd9) begin
        scoreAdd_d[4*d +: 4] = 4'(digitSum_d - 5'd10);
        carry_d              = 5'd1;
      end else begin
        scoreAdd_d[4*d +: 4] = digitSum_d[3:0];
        carry_d              = 5'd0;
      end
    end
    if (carry_d != 5'd0) begin
      scoreAdd_d = 16'h9999;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ATTRACT;
      scoreBcd_q   <= '0;
      lives_q      <= '0;
      frameCnt_q   <= '0;
      gameActive_q <= 1'b0;
      freeze_q     <= 1'b1;
      astRespawn_q <= 1'b0;
      invuln_q     <= 1'b0;
      gameOver_q   <= 1'b0;
`ifdef HIGH_SCORE_EN
      hiScore_q    <= '0;
`endif
    end else if (bus_io.pixpulse) begin
      astRespawn_q <= 1'b0;
      if (scoring) begin
        scoreBcd_q <= scoreAdd_d;
      end
      case (state_q)
        ATTRACT: begin
          if (bus_io.start_btn) begin
            state_q      <= PLAY;
            lives_q      <= 3'(START_LIVES);
            scoreBcd_q   <= '0;
            astRespawn_q <= 1'b1;
            gameActive_q <= 1'b1;
            freeze_q     <= 1'b0;
          end
        end
        PLAY: begin
          if (bus_io.ship_hit) begin
            if (lives_q > 3'd1) begin
              state_q    <= GRACE;
              lives_q    <= lives_q - 3'd1;
              frameCnt_q <= 8'(GRACE_FRAMES);
              invuln_q   <= 1'b1;
            end else begin
              state_q      <= GAME_OVER;
              lives_q      <= '0;
              frameCnt_q   <= 8'(OVER_FRAMES);
              gameActive_q <= 1'b0;
              freeze_q     <= 1'b1;
              gameOver_q   <= 1'b1;
`ifdef HIGH_SCORE_EN
              // Valid BCD words order the same as their unsigned binary encodings.
              if (scoreAdd_d > hiScore_q) begin
                hiScore_q <= scoreAdd_d;
              end
`endif
            end
          end
        end
        GRACE: begin
          if (bus_io.move) begin
            frameCnt_q <= frameCnt_q - 8'd1;
            if (frameCnt_q == 8'd1) begin
              state_q  <= PLAY;
              invuln_q <= 1'b0;
            end
          end
        end
        GAME_OVER: begin
          if (bus_io.move) begin
            frameCnt_q <= frameCnt_q - 8'd1;
            if (frameCnt_q == 8'd1) begin
              state_q    <= ATTRACT;
              gameOver_q <= 1'b0;
            end
          end
        end
        default: state_q <= ATTRACT;
      endcase
    end
  end

  assign bus_io.score_bcd   = scoreBcd_q;
  assign bus_io.lives       = lives_q;
  assign bus_io.game_active = gameActive_q;
  assign bus_io.freeze      = freeze_q;
  assign bus_io.ast_respawn = astRespawn_q;
  assign bus_io.invuln      = invuln_q;
  assign bus_io.game_over   = gameOver_q;

endmodule

// File: tb/tb_game_status_keeper.sv
// Randomised self-checking bench for game_status_keeper against an integer-level game model.
// Hi-score checks are compiled in when HIGH_SCORE_EN is defined.
module tb_game_status_keeper;

  localparam int NUM_AST      = 4;
  localparam int START_LIVES  = 3;
  localparam int GRACE_FRAMES = 120;
  localparam int OVER_FRAMES  = 180;

  typedef enum int {PH_ATTRACT, PH_PLAY, PH_GRACE, PH_OVER} phase_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  phase_t mPhase;
  int     mScore;
  int     mLives;
  int     mMovesLeft;
  int     mHi;
  bit     mRespawn;

  game_status_keeper_if #(.NUM_AST(NUM_AST)) bus ();

  game_status_keeper #(
    .NUM_AST     (NUM_AST),
    .START_LIVES (START_LIVES),
    .GRACE_FRAMES(GRACE_FRAMES),
    .OVER_FRAMES (OVER_FRAMES)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void modelReset();
    mPhase     = PH_ATTRACT;
    mScore     = 0;
    mLives     = 0;
    mMovesLeft = 0;
    mHi        = 0;
    mRespawn   = 1'b0;
  endfunction

  // Game rules at the level of whole numbers: score is an integer clamped to 9999.
  function automatic void modelStep(input logic st, input logic hit, input logic mv,
                                    input logic [NUM_AST-1:0] dodged);
    int add;
    add      = $countones(dodged);
    mRespawn = 1'b0;
    case (mPhase)
      PH_ATTRACT: begin
        if (st) begin
          mPhase   = PH_PLAY;
          mLives   = START_LIVES;
          mScore   = 0;
          mRespawn = 1'b1;
        end
      end
      PH_PLAY: begin
        mScore = (mScore + add > 9999) ? 9999 : mScore + add;
        if (hit) begin
          if (mLives > 1) begin
            mLives     = mLives - 1;
            mPhase     = PH_GRACE;
            mMovesLeft = GRACE_FRAMES;
          end else begin
            mLives     = 0;
            mPhase     = PH_OVER;
            mMovesLeft = OVER_FRAMES;
            if (mScore > mHi) mHi = mScore;
          end
        end
      end
      PH_GRACE: begin
        mScore = (mScore + add > 9999) ? 9999 : mScore + add;
        if (mv) begin
          mMovesLeft = mMovesLeft - 1;
          if (mMovesLeft == 0) mPhase = PH_PLAY;
        end
      end
      default: begin
        if (mv) begin
          mMovesLeft = mMovesLeft - 1;
          if (mMovesLeft == 0) mPhase = PH_ATTRACT;
        end
      end
    endcase
  endfunction

  task automatic checkAll();
    checkOutput("score", 32'(bus.score_bcd), 32'(toBcd(mScore)));
    checkOutput("lives", 32'(bus.lives), 32'(mLives));
    checkOutput("gameActive", 32'(bus.game_active), 32'(mPhase == PH_PLAY || mPhase == PH_GRACE));
    checkOutput("freeze", 32'(bus.freeze), 32'(mPhase == PH_ATTRACT || mPhase == PH_OVER));
    checkOutput("astRespawn", 32'(bus.ast_respawn), 32'(mRespawn));
    checkOutput("invuln", 32'(bus.invuln), 32'(mPhase == PH_GRACE));
    checkOutput("gameOver", 32'(bus.game_over), 32'(mPhase == PH_OVER));
`ifdef HIGH_SCORE_EN
    checkOutput("hiScore", 32'(bus.hi_score_bcd), 32'(toBcd(mHi)));
`endif
  endtask

  task automatic randomJunk();
    bus.start_btn  = 1'($urandom);
    bus.ship_hit   = 1'($urandom);
    bus.move       = 1'($urandom);
    bus.ast_dodged = NUM_AST'($urandom);
  endtask

  // One pixpulse-qualified edge followed by three idle edges carrying junk inputs.
  task automatic applyStimulus(input logic st, input logic hit, input logic mv,
                               input logic [NUM_AST-1:0] dodged);
    @(negedge clk);
    bus.pixpulse   = 1'b1;
    bus.start_btn  = st;
    bus.ship_hit   = hit;
    bus.move       = mv;
    bus.ast_dodged = dodged;
    @(negedge clk);
    bus.pixpulse = 1'b0;
    randomJunk();
    modelStep(st, hit, mv, dodged);
    checkAll();
    @(negedge clk);
    randomJunk();
    @(negedge clk);
    randomJunk();
    checkOutput("scoreHold", 32'(bus.score_bcd), 32'(toBcd(mScore)));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.pixpulse = 1'b0;
    randomJunk();
    #2;
    modelReset();
    checkAll();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic addDodges(input int n);
    int remaining;
    int k;
    remaining = n;
    while (remaining > 0) begin
      k = (remaining > NUM_AST) ? NUM_AST : remaining;
      applyStimulus(1'b0, 1'b0, 1'b0, NUM_AST'((1 << k) - 1));
      remaining = remaining - k;
    end
  endtask

  task automatic moves(input int n, input logic st);
    for (int i = 0; i < n; i++) applyStimulus(st, 1'b0, 1'b1, '0);
  endtask

  task automatic playToOver(input int points);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    addDodges(points);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    moves(GRACE_FRAMES, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    moves(GRACE_FRAMES, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    checkCount     = 0;
    errorCount     = 0;
    rst            = 1'b0;
    bus.pixpulse   = 1'b0;
    bus.start_btn  = 1'b0;
    bus.ship_hit   = 1'b0;
    bus.move       = 1'b0;
    bus.ast_dodged = '0;
    modelReset();
    doReset();

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("startRespawn", 32'(bus.ast_respawn), 32'd1);
    checkOutput("startLives", 32'(bus.lives), 32'd3);
    checkOutput("startFreeze", 32'(bus.freeze), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1011);
    checkOutput("firstDodge", 32'(bus.score_bcd), 32'h0003);
    addDodges(39);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("hitLives", 32'(bus.lives), 32'd2);
    checkOutput("hitInvuln", 32'(bus.invuln), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("graceHitIgnored", 32'(bus.lives), 32'd2);
    moves(GRACE_FRAMES - 1, 1'b0);
    checkOutput("graceLastTick", 32'(bus.invuln), 32'd1);
    moves(1, 1'b0);
    checkOutput("graceDone", 32'(bus.invuln), 32'd0);
    checkOutput("midScore", 32'(bus.score_bcd), 32'h0042);
    doReset();
    checkOutput("rstScore", 32'(bus.score_bcd), 32'h0000);
    checkOutput("rstFreeze", 32'(bus.freeze), 32'd1);

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    addDodges(998);
    checkOutput("score998", 32'(bus.score_bcd), 32'h0998);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
    checkOutput("score1002", 32'(bus.score_bcd), 32'h1002);
    addDodges(8995);
    checkOutput("score9997", 32'(bus.score_bcd), 32'h9997);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
    checkOutput("saturate", 32'(bus.score_bcd), 32'h9999);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
    checkOutput("saturateHold", 32'(bus.score_bcd), 32'h9999);
    doReset();

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    addDodges(10);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    moves(GRACE_FRAMES, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    moves(GRACE_FRAMES, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001);
    checkOutput("lastHitScore", 32'(bus.score_bcd), 32'h0011);
    checkOutput("lastHitLives", 32'(bus.lives), 32'd0);
    checkOutput("lastHitOver", 32'(bus.game_over), 32'd1);
    checkOutput("lastHitFreeze", 32'(bus.freeze), 32'd1);
    moves(OVER_FRAMES - 1, 1'b1);
    checkOutput("overHeld", 32'(bus.game_over), 32'd1);
    moves(1, 1'b1);
    checkOutput("overExit", 32'(bus.game_over), 32'd0);
    checkOutput("attractFreeze", 32'(bus.freeze), 32'd1);
    checkOutput("attractIdle", 32'(bus.game_active), 32'd0);

    doReset();
    playToOver(15);
`ifdef HIGH_SCORE_EN
    checkOutput("hiGame1", 32'(bus.hi_score_bcd), 32'h0015);
`endif
    moves(OVER_FRAMES, 1'b0);
    playToOver(9);
`ifdef HIGH_SCORE_EN
    checkOutput("hiGame2", 32'(bus.hi_score_bcd), 32'h0015);
`endif
    moves(OVER_FRAMES, 1'b0);
    playToOver(20);
`ifdef HIGH_SCORE_EN
    checkOutput("hiGame3", 32'(bus.hi_score_bcd), 32'h0020);
`endif
    moves(OVER_FRAMES, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        doReset();
      end else begin
        applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 24) == 0),
                      ($urandom_range(0, 2) == 0), NUM_AST'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
